spi_link_sched: RTL and testbench

// - Shares the single MCU-side SPI link (sclk/mosi/miso/nss) into the JTAG-SPI byte bridge between two byte-stream requesters.
// - Requesters: 0 = CPU firmware path, 1 = debug/loopback path. Round-robin arbitration at burst granularity.
// - Built-in SPI mode-0 master shifter. Throttles on the bridge's synchronized busy flag (mifull).

---
 rtl/spi_link_sched.sv | 253 +++++++++++++++++++++++++
 tb/tb_spi_link_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_link_sched.sv
// Two-requester burst scheduler driving a mode-0 SPI master into the JTAG-SPI byte bridge.
// Optional busy timeout: define SPI_BUSY_TMO_EN.
module spi_link_sched #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned TMO_CYC   = 4096
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    output logic       rsp0_valid,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       rsp1_valid,
    output logic [7:0] rsp_data,
    output logic       grant_id,
    input  logic       busy_in,
    output logic       sclk,
    output logic       mosi,
    output logic       nss,
    input  logic       miso,
    output logic       err_tmo
);

    localparam int unsigned CW = 9;
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLK_DIV - 1);
    localparam logic [7:0]    BURST_MAX = 8'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LOAD,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t      state_q, state_d;
    logic        busy_meta, busy_sync;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        miso_smp_q, miso_smp_d;
    logic        last_q, last_d;
    logic [7:0]  burst_q, burst_d;
    logic        grant_d, sclk_d, mosi_d, nss_d;
    logic        rdy0_d, rdy1_d, rsp0_d, rsp1_d;
    logic [7:0]  rsp_data_d;
    logic        own_valid, own_last;
    logic [7:0]  own_data;

`ifdef SPI_BUSY_TMO_EN
    localparam int unsigned TW = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_d;
`else
    logic tmo_cfg_unused;
    assign tmo_cfg_unused = |32'(TMO_CYC);
    assign err_tmo = 1'b0;
`endif

    // busy_in comes from another clock domain
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_meta <= 1'b0;
            busy_sync <= 1'b0;
        end else begin
            busy_meta <= busy_in;
            busy_sync <= busy_meta;
        end
    end

    assign own_valid = grant_id ? req1_valid : req0_valid;
    assign own_data  = grant_id ? req1_data  : req0_data;
    assign own_last  = grant_id ? req1_last  : req0_last;

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        miso_smp_d = miso_smp_q;
        last_d     = last_q;
        burst_d    = burst_q;
        grant_d    = grant_id;
        sclk_d     = sclk;
        mosi_d     = mosi;
        nss_d      = nss;
        rdy0_d     = 1'b0;
        rdy1_d     = 1'b0;
        rsp0_d     = 1'b0;
        rsp1_d     = 1'b0;
        rsp_data_d = rsp_data;
`ifdef SPI_BUSY_TMO_EN
        tmo_d      = '0;
        err_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                sclk_d = 1'b0;
                nss_d  = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if ((req0_valid || req1_valid) && !busy_sync) begin
                    state_d = S_ARB;
                    nss_d   = 1'b0;
                end
            end
            S_ARB: begin
                nss_d   = 1'b0;
                state_d = S_LOAD;
                if (req0_valid && req1_valid) begin
                    grant_d = ~grant_id;
                end else if (req0_valid) begin
                    grant_d = 1'b0;
                end else if (req1_valid) begin
                    grant_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    nss_d   = 1'b1;
                    cnt_d   = GAP_LAST;
                end
            end
            S_LOAD: begin
                if (own_valid) begin
                    rdy0_d  = ~grant_id;
                    rdy1_d  = grant_id;
                    sh_d    = own_data;
                    last_d  = own_last;
                    mosi_d  = own_data[7];
                    burst_d = burst_q + 8'd1;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!sclk) begin
                        sclk_d     = 1'b1;
                        miso_smp_d = miso;
                    end else begin
                        sclk_d = 1'b0;
                        sh_d   = {sh_q[6:0], miso_smp_q};
                        if (bit_q == 3'd7) begin
                            mosi_d     = 1'b0;
                            rsp_data_d = {sh_q[6:0], miso_smp_q};
                            rsp0_d     = ~grant_id;
                            rsp1_d     = grant_id;
                            state_d    = S_GAP;
                        end else begin
                            mosi_d = sh_q[6];
                            bit_d  = bit_q + 3'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q != GAP_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (!busy_sync) begin
                    if (!last_q && (burst_q < BURST_MAX) && own_valid) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                        nss_d   = 1'b1;
                        burst_d = '0;
                        cnt_d   = GAP_LAST;
                    end
                end
`ifdef SPI_BUSY_TMO_EN
                // Bridge stuck full: abandon the burst and let the other side in
                if (busy_sync) begin
                    if (tmo_q == TMO_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                        nss_d   = 1'b1;
                        burst_d = '0;
                        cnt_d   = GAP_LAST;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            miso_smp_q <= 1'b0;
            last_q     <= 1'b0;
            burst_q    <= '0;
            grant_id   <= 1'b1;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            nss        <= 1'b1;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_data   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            miso_smp_q <= miso_smp_d;
            last_q     <= last_d;
            burst_q    <= burst_d;
            grant_id   <= grant_d;
            sclk       <= sclk_d;
            mosi       <= mosi_d;
            nss        <= nss_d;
            req0_ready <= rdy0_d;
            req1_ready <= rdy1_d;
            rsp0_valid <= rsp0_d;
            rsp1_valid <= rsp1_d;
            rsp_data   <= rsp_data_d;
        end
    end

`ifdef SPI_BUSY_TMO_EN
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q   <= '0;
            err_tmo <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            err_tmo <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_spi_link_sched.sv
// Self-checking bench for spi_link_sched: single-byte vector table plus arbitration, burst cut,
// busy stall, async reset and (with SPI_BUSY_TMO_EN) busy timeout sequences.
module tb_spi_link_sched;

    localparam int CLK_DIV   = 2;
    localparam int MAX_BURST = 4;
    localparam int TMO_CYC   = 64;
    localparam int NSS_LEN   = 1 + 1 + 16 * CLK_DIV + 2 * CLK_DIV;

    logic       sys_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0_valid, req0_last, req0_ready, rsp0_valid;
    logic       req1_valid, req1_last, req1_ready, rsp1_valid;
    logic [7:0] req0_data, req1_data, rsp_data;
    logic       grant_id, busy_in, sclk, mosi, nss, miso, err_tmo;
    logic [1:0] miso_mode = 2'd0;

    always #5 sys_clk = ~sys_clk;

    // 0: loopback, 1: inverted loopback, 2: stuck 0, 3: stuck 1
    assign miso = (miso_mode == 2'd0) ? mosi :
                  (miso_mode == 2'd1) ? ~mosi :
                  (miso_mode == 2'd2) ? 1'b0 : 1'b1;

    spi_link_sched #(.CLK_DIV(CLK_DIV), .MAX_BURST(MAX_BURST), .TMO_CYC(TMO_CYC)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
        .rsp_data(rsp_data), .grant_id(grant_id), .busy_in(busy_in),
        .sclk(sclk), .mosi(mosi), .nss(nss), .miso(miso), .err_tmo(err_tmo)
    );

    // Byte queues: main process writes entries and wrN, requester model owns rdN
    logic [7:0] b0_data [64];
    logic       b0_last [64];
    logic [7:0] b1_data [64];
    logic       b1_last [64];
    int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;

    // Monitor state, written only by the requester/monitor process
    int   cyc = 0, rsp_n = 0, rsp_id = 0, rsp_val = 0, rsp_cyc = 0;
    int   ord_n = 0, ord_cyc = 0;
    logic ord_id [64];
    int   nss_len = 0, nss_cur = 0, nss_rises = 0;
    int   rise_n = 0, hi_run = 0, hi_bad = 0;
    int   err_n = 0, err_wide = 0, err_cyc = 0;
    int   v_cyc = 0, lat = 0;
    logic lat_pend = 1'b0, prev_sclk = 1'b0, prev_nss = 1'b1, prev_err = 1'b0;

    // Requester model and monitor, evaluated on the falling edge
    initial begin
        req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
        forever begin
            @(negedge sys_clk);
            cyc++;
            if (req0_ready) begin rd0++; ord_id[ord_n % 64] = 1'b0; ord_n++; ord_cyc = cyc; end
            if (req1_ready) begin rd1++; ord_id[ord_n % 64] = 1'b1; ord_n++; ord_cyc = cyc; end
            if (rsp0_valid) begin rsp_n++; rsp_id = 0; rsp_val = int'(rsp_data); rsp_cyc = cyc; end
            if (rsp1_valid) begin rsp_n++; rsp_id = 1; rsp_val = int'(rsp_data); rsp_cyc = cyc; end
            if (err_tmo) begin err_n++; err_cyc = cyc; if (prev_err) err_wide++; end
            if (!nss) nss_cur++;
            else if (!prev_nss) begin nss_len = nss_cur; nss_cur = 0; nss_rises++; end
            if (sclk && !prev_sclk) begin
                rise_n++;
                if (lat_pend) begin lat = cyc - v_cyc; lat_pend = 1'b0; end
            end
            if (!reset_n) hi_run = 0;
            else if (sclk) hi_run++;
            else begin
                if (hi_run != 0 && hi_run != CLK_DIV) hi_bad++;
                hi_run = 0;
            end
            prev_sclk = sclk; prev_nss = nss; prev_err = err_tmo;
            if (((rd0 != wr0) || (rd1 != wr1)) && !req0_valid && !req1_valid && nss) begin
                v_cyc = cyc; lat_pend = 1'b1;
            end
            req0_valid = (rd0 != wr0);
            req0_data  = b0_data[rd0 % 64];
            req0_last  = b0_last[rd0 % 64];
            req1_valid = (rd1 != wr1);
            req1_data  = b1_data[rd1 % 64];
            req1_last  = b1_last[rd1 % 64];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int tests = 0, fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge sys_clk); #2; end
    endtask

    task automatic push(input int id, input logic [7:0] d, input logic l);
        if (id == 0) begin b0_data[wr0 % 64] = d; b0_last[wr0 % 64] = l; wr0++; end
        else begin b1_data[wr1 % 64] = d; b1_last[wr1 % 64] = l; wr1++; end
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int k = 0;
        while ((rsp_n < target || !nss) && k < budget) begin tick(1); k++; end
        check(name, int'(k < budget), 1);
        tick(2 * CLK_DIV + 2);
    endtask

    task automatic wait_ord(input int target, input string name);
        int k = 0;
        while (ord_n < target && k < 400) begin tick(1); k++; end
        check(name, int'(ord_n >= target), 1);
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(2);
    endtask

    typedef struct {
        int         id;
        logic [7:0] data;
        logic [1:0] mode;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [6];
    int   exp_rr [4];
    int   exp_cut [7];
    int   r0, rise0, hb0, o0, nr0, d_cyc;

    initial begin
        vecs[0] = '{0, 8'hA5, 2'd0, 8'hA5};
        vecs[1] = '{1, 8'h3C, 2'd0, 8'h3C};
        vecs[2] = '{0, 8'h81, 2'd1, 8'h7E};
        vecs[3] = '{1, 8'h5A, 2'd2, 8'h00};
        vecs[4] = '{0, 8'h01, 2'd3, 8'hFF};
        vecs[5] = '{1, 8'hFE, 2'd0, 8'hFE};
        exp_rr  = '{0, 0, 1, 1};
        exp_cut = '{1, 1, 1, 1, 0, 1, 1};
        busy_in = 1'b0;

        tick(3);
        check("rst_nss", int'(nss), 1);
        check("rst_sclk", int'(sclk), 0);
        check("rst_mosi", int'(mosi), 0);
        check("rst_grant", int'(grant_id), 1);
        check("rst_rsp_data", int'(rsp_data), 0);
        check("rst_ready", int'({req0_ready, req1_ready}), 0);
        check("rst_rsp", int'({rsp0_valid, rsp1_valid}), 0);
        check("rst_err", int'(err_tmo), 0);
        reset_n = 1'b1;
        tick(2);

        // Single-byte transfers from idle
        for (int i = 0; i < 6; i++) begin
            miso_mode = vecs[i].mode;
            r0 = rsp_n; rise0 = rise_n; hb0 = hi_bad;
            push(vecs[i].id, vecs[i].data, 1'b1);
            wait_done(r0 + 1, 300, $sformatf("v%0d_done", i));
            check($sformatf("v%0d_rsp_data", i), rsp_val, int'(vecs[i].exp));
            check($sformatf("v%0d_rsp_id", i), rsp_id, vecs[i].id);
            check($sformatf("v%0d_rsp_cnt", i), rsp_n - r0, 1);
            check($sformatf("v%0d_nss_len", i), nss_len, NSS_LEN);
            check($sformatf("v%0d_sclk_rises", i), rise_n - rise0, 8);
            check($sformatf("v%0d_sclk_width", i), hi_bad - hb0, 0);
            check($sformatf("v%0d_latency", i), lat, 3 + CLK_DIV);
            check($sformatf("v%0d_grant", i), int'(grant_id), vecs[i].id);
        end
        miso_mode = 2'd0;

        // Round robin: both requesters with 2-byte bursts, twice
        reset_dut();
        for (int rnd = 0; rnd < 2; rnd++) begin
            o0 = ord_n; r0 = rsp_n;
            push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b1);
            push(1, 8'h33, 1'b0); push(1, 8'h44, 1'b1);
            wait_done(r0 + 4, 600, $sformatf("rr%0d_done", rnd));
            for (int i = 0; i < 4; i++)
                check($sformatf("rr%0d_order%0d", rnd, i), int'(ord_id[(o0 + i) % 64]), exp_rr[i]);
            check($sformatf("rr%0d_last_rsp", rnd), rsp_val, 8'h44);
            check($sformatf("rr%0d_grant", rnd), int'(grant_id), 1);
        end

        // Burst cut at MAX_BURST lets the waiting requester in
        o0 = ord_n; r0 = rsp_n; nr0 = nss_rises;
        for (int i = 0; i < 6; i++) push(1, 8'(8'h50 + i), 1'b0);
        wait_ord(o0 + 1, "cut_start");
        push(0, 8'hC3, 1'b1);
        wait_done(r0 + 7, 1500, "cut_done");
        for (int i = 0; i < 7; i++)
            check($sformatf("cut_order%0d", i), int'(ord_id[(o0 + i) % 64]), exp_cut[i]);
        check("cut_nss_rises", nss_rises - nr0, 3);

        // Busy during the gap holds the burst with nss low
        o0 = ord_n; r0 = rsp_n; rise0 = rise_n; nr0 = nss_rises;
        push(0, 8'h6A, 1'b0); push(0, 8'h96, 1'b0); push(0, 8'h5C, 1'b1);
        wait_ord(o0 + 1, "busy_start");
        busy_in = 1'b1;
        tick(100);
        check("busy_rsp_cnt", rsp_n - r0, 1);
        check("busy_sclk_rises", rise_n - rise0, 8);
        check("busy_nss_held", nss_rises - nr0, 0);
        check("busy_nss", int'(nss), 0);
        check("busy_sclk", int'(sclk), 0);
        d_cyc = cyc;
        busy_in = 1'b0;
        wait_ord(o0 + 2, "busy_resume");
        check("busy_resume_delay", ord_cyc - d_cyc, 5);
        wait_done(r0 + 3, 400, "busy_done");
        check("busy_rsp_total", rsp_n - r0, 3);
        check("busy_last_rsp", rsp_val, 8'h5C);
        check("busy_one_burst", nss_rises - nr0, 1);

        // Asynchronous reset in the middle of a byte
        r0 = rsp_n; rise0 = rise_n;
        push(0, 8'h9B, 1'b1);
        begin
            int k = 0;
            while (rise_n < rise0 + 4 && k < 200) begin tick(1); k++; end
            check("rst_mid_reach", int'(k < 200), 1);
        end
        reset_n = 1'b0;
        #1;
        check("rst_mid_nss", int'(nss), 1);
        check("rst_mid_sclk", int'(sclk), 0);
        tick(3);
        check("rst_mid_no_rsp", rsp_n - r0, 0);
        reset_n = 1'b1;
        tick(2);
        check("rst_mid_grant", int'(grant_id), 1);
        push(0, 8'h9B, 1'b1);
        wait_done(r0 + 1, 300, "rst_retry_done");
        check("rst_retry_rsp", rsp_val, 8'h9B);
        check("rst_retry_nss_len", nss_len, NSS_LEN);

`ifdef SPI_BUSY_TMO_EN
        // Busy stuck high aborts the burst after TMO_CYC gap cycles
        o0 = ord_n; r0 = rsp_n;
        push(0, 8'h77, 1'b0); push(0, 8'h88, 1'b1);
        wait_ord(o0 + 1, "tmo_start");
        busy_in = 1'b1;
        begin
            int k = 0;
            int e0 = err_n;
            while (err_n == e0 && k < 400) begin tick(1); k++; end
            check("tmo_seen", int'(k < 400), 1);
        end
        check("tmo_delay", err_cyc - rsp_cyc, TMO_CYC);
        check("tmo_nss", int'(nss), 1);
        tick(20);
        check("tmo_pulse_width", err_wide, 0);
        check("tmo_no_regrant", ord_n - o0, 1);
        busy_in = 1'b0;
        wait_done(r0 + 2, 400, "tmo_recover");
        check("tmo_recover_rsp", rsp_val, 8'h88);
        check("tmo_err_count", err_n, 1);
`else
        check("err_tmo_quiet", err_n, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
